// File: rtl/lcd_pkg.sv
// Shared constants, FSM states and DDRAM address helpers for the HD44780 responder.
package lcd_pkg;

    // Instruction opcode masks; an instruction is identified by its highest set bit.
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    // DDRAM geometry: two 40-character lines at 0x00 and 0x40, 80 bytes total.
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         LINE_LEN   = 40;
    localparam int         DDRAM_SIZE = 80;
    localparam logic [7:0] BLANK      = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    // Map an HD44780 DDRAM address onto the packed 0..79 storage index.
    function automatic logic [6:0] phys_addr(input logic [6:0] a, input logic two_line);
        if (two_line && (a >= LINE1_BASE)) begin
            return a - LINE1_BASE + 7'(LINE_LEN);
        end
        return a;
    endfunction

    // True when a Set-DDRAM-address request names a real character cell.
    function automatic logic addr_valid(input logic [6:0] a, input logic two_line);
        if (two_line) begin
            return (a < LINE0_BASE + 7'(LINE_LEN)) ||
                   ((a >= LINE1_BASE) && (a < LINE1_BASE + 7'(LINE_LEN)));
        end
        return a < 7'(DDRAM_SIZE);
    endfunction

    // Move the address counter one cell, jumping between lines in two-line mode.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic two_line);
        if (two_line) begin
            if (inc) begin
                if (a == LINE0_BASE + 7'(LINE_LEN - 1)) return LINE1_BASE;
                if (a == LINE1_BASE + 7'(LINE_LEN - 1)) return LINE0_BASE;
                return a + 7'd1;
            end
            if (a == LINE0_BASE) return LINE1_BASE + 7'(LINE_LEN - 1);
            if (a == LINE1_BASE) return LINE0_BASE + 7'(LINE_LEN - 1);
            return a - 7'd1;
        end
        if (inc) begin
            return (a == 7'(DDRAM_SIZE - 1)) ? 7'd0 : a + 7'd1;
        end
        return (a == 7'd0) ? 7'(DDRAM_SIZE - 1) : a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, one registered read port.
// A same-cycle write and read of one location returns the old byte.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       we,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [DDRAM_SIZE];

    // Write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, output register cleared on reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible bus responder: latches writes on E falling edges,
// decodes instructions, mirrors DDRAM and models the controller busy time.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int T_SHORT  = int'(CLK_FREQ * 40.0e-6),
    parameter int T_LONG   = int'(CLK_FREQ * 1.52e-3),
    parameter int E_MIN    = int'(CLK_FREQ * 230.0e-9)
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       e,
    input  logic [7:0] d,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       two_line,
    output logic       eight_bit,
    output logic       cmd_strobe,
    output logic       char_strobe,
    output logic       busy_violation,
    output logic       timing_error,
    output logic       addr_error
);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [6:0]  clr_idx_q, clr_idx_d;
    logic        e_q;
    logic [31:0] hi_cnt_q, hi_cnt_d;
    logic [6:0]  ac_q, ac_d;
    logic        display_on_q, display_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
    logic        entry_inc_q, entry_inc_d, entry_shift_q, entry_shift_d;
    logic        two_line_q, two_line_d, eight_bit_q, eight_bit_d;
    logic        cmd_strobe_q, cmd_strobe_d, char_strobe_q, char_strobe_d;
    logic        busy_violation_q, busy_violation_d, timing_error_q, timing_error_d;
    logic        addr_error_q, addr_error_d;
    logic        fall;
    logic        we;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;

    assign fall = e_q & ~e;

    // State register plus E edge detector and high-width counter.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state_q          <= S_IDLE;
            timer_q          <= '0;
            clr_idx_q        <= '0;
            e_q              <= 1'b0;
            hi_cnt_q         <= '0;
            ac_q             <= '0;
            display_on_q     <= 1'b0;
            cursor_on_q      <= 1'b0;
            blink_on_q       <= 1'b0;
            entry_inc_q      <= 1'b1;
            entry_shift_q    <= 1'b0;
            two_line_q       <= 1'b0;
            eight_bit_q      <= 1'b1;
            cmd_strobe_q     <= 1'b0;
            char_strobe_q    <= 1'b0;
            busy_violation_q <= 1'b0;
            timing_error_q   <= 1'b0;
            addr_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            clr_idx_q        <= clr_idx_d;
            e_q              <= e;
            hi_cnt_q         <= hi_cnt_d;
            ac_q             <= ac_d;
            display_on_q     <= display_on_d;
            cursor_on_q      <= cursor_on_d;
            blink_on_q       <= blink_on_d;
            entry_inc_q      <= entry_inc_d;
            entry_shift_q    <= entry_shift_d;
            two_line_q       <= two_line_d;
            eight_bit_q      <= eight_bit_d;
            cmd_strobe_q     <= cmd_strobe_d;
            char_strobe_q    <= char_strobe_d;
            busy_violation_q <= busy_violation_d;
            timing_error_q   <= timing_error_d;
            addr_error_q     <= addr_error_d;
        end
    end

    // Next-state: busy countdown, clear sweep, and decode of accepted E pulses.
    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        clr_idx_d        = clr_idx_q;
        ac_d             = ac_q;
        display_on_d     = display_on_q;
        cursor_on_d      = cursor_on_q;
        blink_on_d       = blink_on_q;
        entry_inc_d      = entry_inc_q;
        entry_shift_d    = entry_shift_q;
        two_line_d       = two_line_q;
        eight_bit_d      = eight_bit_q;
        cmd_strobe_d     = 1'b0;
        char_strobe_d    = 1'b0;
        busy_violation_d = busy_violation_q;
        timing_error_d   = timing_error_q;
        addr_error_d     = addr_error_q;
        hi_cnt_d         = e ? ((hi_cnt_q == 32'hFFFF_FFFF) ? hi_cnt_q : hi_cnt_q + 32'd1) : 32'd0;
        we               = 1'b0;
        wr_addr          = phys_addr(ac_q, two_line_q);
        wr_data          = d;

        case (state_q)
            S_CLEAR: begin
                // Busy timer already runs here so Clear totals exactly T_LONG.
                we      = 1'b1;
                wr_addr = clr_idx_q;
                wr_data = BLANK;
                timer_d = timer_q - 32'd1;
                if (clr_idx_q == 7'(DDRAM_SIZE - 1)) begin
                    state_d = S_BUSY;
                end else begin
                    clr_idx_d = clr_idx_q + 7'd1;
                end
            end
            S_BUSY: begin
                if (timer_q == 32'd0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: ;
        endcase

        if (fall) begin
            if (hi_cnt_q < 32'(E_MIN)) begin
                timing_error_d = 1'b1;
            end else if (rw) begin
                // Reads are not modelled; the pulse is simply dropped.
            end else if (state_q != S_IDLE) begin
                busy_violation_d = 1'b1;
            end else begin
                state_d = S_BUSY;
                timer_d = 32'(T_SHORT - 1);
                if (rs) begin
                    we            = 1'b1;
                    char_strobe_d = 1'b1;
                    ac_d          = ac_step(ac_q, entry_inc_q, two_line_q);
                end else begin
                    cmd_strobe_d = 1'b1;
                    if ((d & OP_DDRAM) != 8'h00) begin
                        if (addr_valid(d[6:0], two_line_q)) begin
                            ac_d = d[6:0];
                        end else begin
                            addr_error_d = 1'b1;
                        end
                    end else if ((d & OP_CGRAM) != 8'h00) begin
                        // CGRAM is not mirrored.
                    end else if ((d & OP_FUNC) != 8'h00) begin
                        eight_bit_d = d[4];
                        two_line_d  = d[3];
                    end else if ((d & OP_SHIFT) != 8'h00) begin
                        // Display shift leaves DDRAM alone; only cursor moves matter.
                        if (!d[3]) begin
                            ac_d = ac_step(ac_q, d[2], two_line_q);
                        end
                    end else if ((d & OP_DISPLAY) != 8'h00) begin
                        display_on_d = d[2];
                        cursor_on_d  = d[1];
                        blink_on_d   = d[0];
                    end else if ((d & OP_ENTRY) != 8'h00) begin
                        entry_inc_d   = d[1];
                        entry_shift_d = d[0];
                    end else if ((d & OP_HOME) != 8'h00) begin
                        ac_d    = '0;
                        timer_d = 32'(T_LONG - 1);
                    end else if ((d & OP_CLEAR) != 8'h00) begin
                        state_d     = S_CLEAR;
                        clr_idx_d   = '0;
                        ac_d        = '0;
                        entry_inc_d = 1'b1;
                        timer_d     = 32'(T_LONG - 1);
                    end
                end
            end
        end
    end

    lcd_ddram u_ddram (
        .clk     (clock),
        .srst    (internal_reset),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy           = (state_q != S_IDLE);
    assign cursor_addr    = ac_q;
    assign display_on     = display_on_q;
    assign cursor_on      = cursor_on_q;
    assign blink_on       = blink_on_q;
    assign entry_inc      = entry_inc_q;
    assign entry_shift    = entry_shift_q;
    assign two_line       = two_line_q;
    assign eight_bit      = eight_bit_q;
    assign cmd_strobe     = cmd_strobe_q;
    assign char_strobe    = char_strobe_q;
    assign busy_violation = busy_violation_q;
    assign timing_error   = timing_error_q;
    assign addr_error     = addr_error_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: stimulus updates a line/column model of the
// display and queues expected strobe records and busy lengths; a monitor pops them.
module tb_lcd_responder;

    localparam int TS = 40;
    localparam int TL = 300;
    localparam int EM = 12;

    logic       clock = 1'b0;
    logic       internal_reset;
    logic       rs, rw, e;
    logic [7:0] d;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, entry_inc, entry_shift, two_line, eight_bit;
    logic       cmd_strobe, char_strobe, busy_violation, timing_error, addr_error;

    lcd_responder #(.T_SHORT(TS), .T_LONG(TL), .E_MIN(EM)) dut (
        .clock          (clock),
        .internal_reset (internal_reset),
        .rs             (rs),
        .rw             (rw),
        .e              (e),
        .d              (d),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .cursor_addr    (cursor_addr),
        .display_on     (display_on),
        .cursor_on      (cursor_on),
        .blink_on       (blink_on),
        .entry_inc      (entry_inc),
        .entry_shift    (entry_shift),
        .two_line       (two_line),
        .eight_bit      (eight_bit),
        .cmd_strobe     (cmd_strobe),
        .char_strobe    (char_strobe),
        .busy_violation (busy_violation),
        .timing_error   (timing_error),
        .addr_error     (addr_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ac;
    bit         m_two, m_eight, m_inc, m_shift, m_disp, m_cur, m_blink;
    bit         m_terr, m_bviol, m_aerr;
    logic [7:0] m_mem [80];
    longint     busy_end;

    typedef struct {
        longint     t;
        bit         is_char;
        int         ac;
        logic [6:0] mode;
    } exp_t;
    exp_t sb_q[$];
    int   busy_q[$];

    function automatic logic [6:0] m_mode();
        return {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_eight};
    endfunction

    // Linear cell position 0..79 (line*40 + column) of a DDRAM address.
    function automatic int to_pos(input int a, input bit two);
        if (two && a >= 64) return a - 64 + 40;
        return a;
    endfunction

    function automatic int from_pos(input int p, input bit two);
        if (two && p >= 40) return p - 40 + 64;
        return p;
    endfunction

    function automatic int step_addr(input int a, input bit two, input bit inc);
        return from_pos((to_pos(a, two) + (inc ? 1 : 79)) % 80, two);
    endfunction

    function automatic bit valid_addr(input int a, input bit two);
        if (two) return (a < 40) || (a >= 64 && a < 104);
        return a < 80;
    endfunction

    task automatic m_reset();
        m_ac = 0; m_two = 0; m_eight = 1; m_inc = 1; m_shift = 0;
        m_disp = 0; m_cur = 0; m_blink = 0;
        m_terr = 0; m_bviol = 0; m_aerr = 0;
        busy_end = 0;
        sb_q.delete();
        busy_q.delete();
    endtask

    task automatic model_apply(input bit prs, input bit prw, input logic [7:0] pd,
                               input int width, input longint t);
        int   dur;
        exp_t x;
        if (width < EM) begin
            m_terr = 1;
        end else if (prw) begin
        end else if (t <= busy_end) begin
            m_bviol = 1;
        end else begin
            dur = TS;
            if (prs) begin
                m_mem[to_pos(m_ac, m_two)] = pd;
                m_ac = step_addr(m_ac, m_two, m_inc);
            end else if (pd[7]) begin
                if (valid_addr(int'(pd[6:0]), m_two)) m_ac = int'(pd[6:0]);
                else m_aerr = 1;
            end else if (pd[6]) begin
            end else if (pd[5]) begin
                m_eight = pd[4]; m_two = pd[3];
            end else if (pd[4]) begin
                if (!pd[3]) m_ac = step_addr(m_ac, m_two, pd[2]);
            end else if (pd[3]) begin
                m_disp = pd[2]; m_cur = pd[1]; m_blink = pd[0];
            end else if (pd[2]) begin
                m_inc = pd[1]; m_shift = pd[0];
            end else if (pd[1]) begin
                m_ac = 0; dur = TL;
            end else if (pd[0]) begin
                for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
                m_ac = 0; m_inc = 1; dur = TL;
            end
            busy_end  = t + dur;
            x.t       = t;
            x.is_char = prs;
            x.ac      = m_ac;
            x.mode    = m_mode();
            sb_q.push_back(x);
            busy_q.push_back(dur);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    longint last_fall;

    task automatic pulse(input bit prs, input bit prw, input logic [7:0] pd, input int width);
        @(posedge clock);
        #1;
        rs = prs; rw = prw; d = pd; e = 1'b1;
        repeat (width) @(posedge clock);
        #1;
        e = 1'b0;
        @(posedge clock);
        last_fall = longint'($time / 10);
        model_apply(prs, prw, pd, width, last_fall);
    endtask

    task automatic settle();
        while (longint'($time / 10) <= busy_end + 1) @(posedge clock);
        repeat (2) @(posedge clock);
    endtask

    task automatic wr(input bit prs, input logic [7:0] pd);
        pulse(prs, 1'b0, pd, EM + 2);
        settle();
    endtask

    task automatic rd_check(input int p);
        @(posedge clock);
        #1;
        rd_addr = 7'(p);
        @(posedge clock);
        @(negedge clock);
        check($sformatf("ddram[%0d]", p), longint'(rd_data), longint'(m_mem[p]));
    endtask

    task automatic chk_regs(input string tag);
        @(negedge clock);
        check({tag, "_ac"}, longint'(cursor_addr), longint'(m_ac));
        check({tag, "_mode"}, longint'({display_on, cursor_on, blink_on, entry_inc,
                                        entry_shift, two_line, eight_bit}), longint'(m_mode()));
        check({tag, "_flags"}, longint'({busy_violation, timing_error, addr_error}),
              longint'({m_bviol, m_terr, m_aerr}));
    endtask

    // ---------------- monitor ----------------
    int bcount = 0;

    always @(negedge clock) begin
        exp_t x;
        longint now_c;
        int     bexp;
        if (internal_reset) begin
            bcount = 0;
        end else begin
            now_c = longint'($time / 10) - 1;
            if (cmd_strobe || char_strobe) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    x = sb_q.pop_front();
                    check("strobe_time", now_c, x.t);
                    check("strobe_kind", longint'(char_strobe), longint'(x.is_char));
                    check("strobe_ac", longint'(cursor_addr), longint'(x.ac));
                    check("strobe_mode", longint'({display_on, cursor_on, blink_on, entry_inc,
                                                   entry_shift, two_line, eight_bit}),
                          longint'(x.mode));
                end
            end
            if (busy) begin
                bcount++;
            end else if (bcount > 0) begin
                if (busy_q.size() == 0) begin
                    check("unexpected_busy", longint'(bcount), 0);
                end else begin
                    bexp = busy_q.pop_front();
                    check("busy_len", longint'(bcount), longint'(bexp));
                end
                bcount = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] init_seq [8];
        logic [7:0] old;
        int         r, w;
        logic [7:0] op;

        init_seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        internal_reset = 1'b1;
        rs = 0; rw = 0; e = 0; d = 8'h00; rd_addr = 7'd0;
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        internal_reset = 1'b0;
        m_reset();

        // Reset state
        @(negedge clock);
        check("reset_busy", longint'(busy), 0);
        check("reset_strobes", longint'({cmd_strobe, char_strobe}), 0);
        check("reset_rd_data", longint'(rd_data), 0);
        chk_regs("reset");

        // Initialisation sequence
        foreach (init_seq[i]) wr(1'b0, init_seq[i]);
        chk_regs("init");

        // First character with same-cycle read of the written cell
        @(posedge clock);
        #1;
        rd_addr = 7'd0;
        old = m_mem[0];
        pulse(1'b1, 1'b0, 8'h41, EM + 2);
        @(negedge clock);
        check("same_cycle_read_old", longint'(rd_data), longint'(old));
        @(negedge clock);
        check("read_after_write", longint'(rd_data), 64'h41);
        settle();
        chk_regs("char_a");

        // End of line 1 jumps to line 2
        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h5A);
        rd_check(39);
        chk_regs("line_wrap");

        // Two-line boundaries in both directions
        wr(1'b0, 8'hE7);
        wr(1'b1, 8'h11);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h22);
        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h33);
        wr(1'b0, 8'h06);
        chk_regs("boundaries");
        rd_check(79);
        rd_check(0);
        rd_check(40);

        // Randomized traffic in two-line mode, including short gaps and narrow pulses
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: op = 8'($urandom_range(33, 126));
                4: op = ($urandom_range(0, 4) == 0) ? 8'(8'h80 | $urandom_range(40, 63))
                                                    : 8'(8'h80 | from_pos($urandom_range(0, 79), 1'b1));
                5: op = 8'(8'h04 | $urandom_range(0, 3));
                6: op = 8'(8'h08 | $urandom_range(0, 7));
                7: op = 8'(8'h10 | $urandom_range(0, 15));
                8: op = 8'(8'h28 | ($urandom_range(0, 1) << 4));
                default: op = 8'(8'h02 | $urandom_range(0, 1));
            endcase
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(3, EM - 1) : $urandom_range(EM, EM + 4);
            pulse((r <= 3) ? 1'b1 : 1'b0, 1'b0, op, w);
            if ($urandom_range(0, 4) != 0) settle();
        end
        settle();
        chk_regs("random");
        for (int p = 0; p < 80; p += 7) rd_check(p);

        // Clear after characters
        wr(1'b0, 8'h01);
        chk_regs("clear");
        for (int p = 0; p < 80; p++) rd_check(p);

        // Clear sticky flags before the directed error cases
        @(posedge clock);
        #1;
        internal_reset = 1'b1;
        @(posedge clock);
        #1;
        internal_reset = 1'b0;
        m_reset();
        chk_regs("reset2");
        wr(1'b0, 8'h38);
        wr(1'b0, 8'h06);

        // Busy violation: second pulse while the first character is still busy
        pulse(1'b1, 1'b0, 8'h61, EM + 2);
        pulse(1'b1, 1'b0, 8'h62, EM);
        settle();
        chk_regs("busy_viol");
        rd_check(0);
        rd_check(1);

        // Narrow pulse, read pulse, then invalid address in two-line mode
        pulse(1'b1, 1'b0, 8'h63, 5);
        settle();
        pulse(1'b1, 1'b1, 8'h64, EM + 2);
        settle();
        wr(1'b0, 8'hB0);
        chk_regs("errors");
        rd_check(1);

        // One-line mode wraps modulo 80
        wr(1'b0, 8'h30);
        wr(1'b0, 8'hCF);
        wr(1'b1, 8'h71);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h72);
        wr(1'b0, 8'hB0);
        chk_regs("one_line");
        rd_check(79);
        rd_check(0);
        rd_check(48);

        // Reset in the middle of a Clear leaves the partial fill
        wr(1'b0, 8'h94);
        wr(1'b1, 8'h58);
        wr(1'b1, 8'h59);
        pulse(1'b0, 1'b0, 8'h01, EM + 2);
        repeat (20) @(posedge clock);
        #1;
        internal_reset = 1'b1;
        @(posedge clock);
        #1;
        internal_reset = 1'b0;
        for (int i = 0; i <= 20; i++) m_mem[i] = 8'h20;
        m_reset();
        @(negedge clock);
        check("midclear_busy", longint'(busy), 0);
        chk_regs("midclear");
        rd_check(20);
        rd_check(21);

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("sb_left", longint'(sb_q.size()), 0);
        check("busy_left", longint'(busy_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
